// File: rtl/ir_packet_tx.sv
// IR packet transmitter for remote-controlled cars.
// A packet is a fixed sequence of carrier bursts and silent gaps: START, CARSEL and
// four drive-field bursts (RIGHT, LEFT, BACK, FWD). Each burst is long or short
// depending on its latched COMMAND bit. The selected car colour sets both the
// carrier frequency and the burst/gap lengths.
module ir_packet_tx #(
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COMMAND,
    input  logic [3:0] COLOR_SEL,
    input  logic       SEND_PACKET,
    output logic       IR_LED,
    output logic       BUSY
);

    // Carrier half-periods in clocks, rounded to the nearest integer.
    localparam int H_BLUE   = (CLK_FREQ_HZ + 36000) / 72000;
    localparam int H_YELLOW = (CLK_FREQ_HZ + 40000) / 80000;
    localparam int H_GREEN  = (CLK_FREQ_HZ + 37500) / 75000;
    localparam int H_RED    = H_BLUE;

    // Blue/red have the lowest carrier, so the longest half-period; never below 11 bits.
    localparam int HALF_W = ($clog2(H_BLUE + 1) > 11) ? $clog2(H_BLUE + 1) : 11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_GAP1,
        S_CARSEL,
        S_GAP2,
        S_RIGHT,
        S_GAP3,
        S_LEFT,
        S_GAP4,
        S_BACK,
        S_GAP5,
        S_FWD
    } state_t;

    state_t state, state_next, following;

    logic [HALF_W-1:0] half_cnt, half_cnt_next, half_len;
    logic [7:0]        period_cnt, period_cnt_next;
    logic [7:0]        start_len, gap_len, carsel_len, assert_len, deassert_len, seg_len;
    logic              phase, phase_next;
    logic              led_q, led_next, busy_q, busy_next;
    logic [3:0]        cmd_latched, cmd_next, color_latched, color_next;
    logic              color_onehot, half_end, seg_done, cur_burst, following_burst;

    assign color_onehot = (COLOR_SEL != 4'b0000) && ((COLOR_SEL & (COLOR_SEL - 4'd1)) == 4'b0000);
    assign half_end     = (half_cnt == half_len - HALF_W'(1));
    assign seg_done     = half_end && phase && (period_cnt == seg_len - 8'd1);

    assign IR_LED = led_q;
    assign BUSY   = busy_q;

    // Per-colour timing table, selected by the colour latched at packet start.
    always_comb begin
        half_len     = HALF_W'(H_BLUE);
        start_len    = 8'd191;
        gap_len      = 8'd25;
        carsel_len   = 8'd47;
        assert_len   = 8'd47;
        deassert_len = 8'd22;
        case (color_latched)
            4'b0010: begin
                half_len     = HALF_W'(H_YELLOW);
                start_len    = 8'd88;
                gap_len      = 8'd40;
                carsel_len   = 8'd22;
                assert_len   = 8'd44;
                deassert_len = 8'd22;
            end
            4'b0100: begin
                half_len     = HALF_W'(H_GREEN);
                start_len    = 8'd88;
                gap_len      = 8'd40;
                carsel_len   = 8'd44;
                assert_len   = 8'd44;
                deassert_len = 8'd22;
            end
            4'b1000: begin
                half_len     = HALF_W'(H_RED);
                start_len    = 8'd192;
                gap_len      = 8'd24;
                carsel_len   = 8'd24;
                assert_len   = 8'd48;
                deassert_len = 8'd24;
            end
            default: ;
        endcase
    end

    // Length of the current segment in carrier periods, its successor, and which states emit carrier.
    always_comb begin
        seg_len         = 8'd0;
        following       = S_IDLE;
        cur_burst       = 1'b0;
        following_burst = 1'b0;
        case (state)
            S_START:  begin seg_len = start_len;  following = S_GAP1;   cur_burst = 1'b1; end
            S_GAP1:   begin seg_len = gap_len;    following = S_CARSEL; following_burst = 1'b1; end
            S_CARSEL: begin seg_len = carsel_len; following = S_GAP2;   cur_burst = 1'b1; end
            S_GAP2:   begin seg_len = gap_len;    following = S_RIGHT;  following_burst = 1'b1; end
            S_RIGHT:  begin seg_len = cmd_latched[0] ? assert_len : deassert_len; following = S_GAP3; cur_burst = 1'b1; end
            S_GAP3:   begin seg_len = gap_len;    following = S_LEFT;   following_burst = 1'b1; end
            S_LEFT:   begin seg_len = cmd_latched[1] ? assert_len : deassert_len; following = S_GAP4; cur_burst = 1'b1; end
            S_GAP4:   begin seg_len = gap_len;    following = S_BACK;   following_burst = 1'b1; end
            S_BACK:   begin seg_len = cmd_latched[2] ? assert_len : deassert_len; following = S_GAP5; cur_burst = 1'b1; end
            S_GAP5:   begin seg_len = gap_len;    following = S_FWD;    following_burst = 1'b1; end
            S_FWD:    begin seg_len = cmd_latched[3] ? assert_len : deassert_len; following = S_IDLE; cur_burst = 1'b1; end
            default:  ;
        endcase
    end

    // Next-state, counter and output logic; outputs are computed one clock ahead so they leave flops.
    always_comb begin
        state_next      = state;
        half_cnt_next   = half_cnt;
        period_cnt_next = period_cnt;
        phase_next      = phase;
        led_next        = led_q;
        busy_next       = busy_q;
        cmd_next        = cmd_latched;
        color_next      = color_latched;
        if (state == S_IDLE) begin
            led_next  = 1'b0;
            busy_next = 1'b0;
            if (SEND_PACKET && color_onehot) begin
                state_next      = S_START;
                half_cnt_next   = '0;
                period_cnt_next = '0;
                phase_next      = 1'b0;
                led_next        = 1'b1;
                busy_next       = 1'b1;
                cmd_next        = COMMAND;
                color_next      = COLOR_SEL;
            end
        end else if (seg_done) begin
            state_next      = following;
            half_cnt_next   = '0;
            period_cnt_next = '0;
            phase_next      = 1'b0;
            led_next        = following_burst;
            busy_next       = (following != S_IDLE);
        end else begin
            if (half_end) begin
                half_cnt_next = '0;
                phase_next    = ~phase;
                if (phase) begin
                    period_cnt_next = period_cnt + 8'd1;
                end
            end else begin
                half_cnt_next = half_cnt + HALF_W'(1);
            end
            led_next = cur_burst && !phase_next;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            half_cnt      <= '0;
            period_cnt    <= '0;
            phase         <= 1'b0;
            led_q         <= 1'b0;
            busy_q        <= 1'b0;
            cmd_latched   <= 4'b0000;
            color_latched <= 4'b0000;
        end else begin
            state         <= state_next;
            half_cnt      <= half_cnt_next;
            period_cnt    <= period_cnt_next;
            phase         <= phase_next;
            led_q         <= led_next;
            busy_q        <= busy_next;
            cmd_latched   <= cmd_next;
            color_latched <= color_next;
        end
    end

endmodule
